image_proc_ctrl: RTL and testbench
==================================

# image_proc_ctrl

In-place transform sequencer for the 64x64x24-bit image memory. On a `start` pulse it walks the frame and drives the memory's row/column/write-enable/data ports. It performs either a vertical mirror (swap row r with row 63-r) or a grayscale conversion, then pulses `done`. It sits between top-level control and the image memory and owns the memory ports for the whole operation.

## Interface
Parameters: none (frame fixed at 64x64, pixel = {R[23:16], G[15:8], B[7:0]}).
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0 = vertical mirror, 1 = grayscale; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse after the last write
- row  out  6  memory row address
- col  out  6  memory column address
- we  out  1  memory write enable
- out_pix  out  24  write data to memory
- in_pix  in  24  read data from memory (combinational read of current row/col)

## Operation
- States: IDLE, MR_TOP, MR_BOT, MR_WB, GRAY, DONE.
- row, col, mode latch, top_buf, bot_buf, r/c counters are registers. we, out_pix, busy, done are decoded from state.
- out_pix = 0 whenever we = 0.
- IDLE: we=0, busy=0. On start=1: latch mode, zero counters, go to MR_TOP (mode 0) or GRAY (mode 1).
- Mirror: r outer 0..31, c inner 0..63.
  - MR_TOP: row=r, col=c, we=0. Capture top_buf <= in_pix. Go to MR_BOT.
  - MR_BOT: row=63-r, col=c, we=1, out_pix=top_buf. Capture bot_buf <= in_pix (old value; the write lands at the same edge). Go to MR_WB.
  - MR_WB: row=r, col=c, we=1, out_pix=bot_buf. Advance c; on c wrap advance r. After (r=31, c=63) go to DONE, else MR_TOP.
- Grayscale: row-major, r 0..63 outer, c 0..63 inner, one pixel per cycle.
  - GRAY: row=r, col=c, we=1.
  - gray = (max(R,G,B) + min(R,G,B)) >> 1, using a 9-bit sum truncated to 8 bits after the shift.
  - out_pix = {8'h00, gray, 8'h00}.
  - After (63,63) go to DONE.
- DONE: we=0, done=1 for one cycle, busy=0. Go to IDLE.
- start while not in IDLE is ignored. mode changes mid-operation are ignored.
- Counters wrap naturally in 6 bits. Terminal detection uses explicit compare, not overflow.

## Timing
- Reset values: row=0, col=0, we=0, out_pix=0, busy=0, done=0, state=IDLE, buffers=0.
- Asserting rst_n low mid-operation returns to IDLE immediately (asynchronously) and drops we the same instant. The partially transformed frame is left as is. No done pulse is issued.
- Start edge = the posedge at which start=1 is sampled in IDLE. The first memory cycle is the next cycle, with busy=1 from then on.
- Mirror: 3 cycles per pair, 2048 pairs = 6144 busy cycles, 4096 write cycles. done asserts in cycle 6145 after the start edge.
- Grayscale: 4096 busy cycles, all with we=1. done asserts in cycle 4097 after the start edge.
- The earliest accepted new start is in the IDLE cycle after DONE. Start asserted during the DONE cycle is ignored.
- in_pix must be valid combinationally within the same cycle as row/col. No read latency is assumed.

## Test plan
- Memory preloaded with pixel(r,c) = r+c, mode=0, start pulse. Required response:
  - busy high for exactly 6144 cycles, then done for 1 cycle.
  - pixel(0,5) = 68, pixel(63,5) = 5, pixel(31,0) = 32, pixel(32,0) = 31.
- Same preload, mode=1. Required response:
  - busy high for exactly 4096 cycles.
  - pixel(10,20) = 24'h000F00, pixel(63,63) = 24'h003F00, pixel(0,0) = 24'h000000.
- Grayscale with preload 24'hFF8001 everywhere: every pixel becomes 24'h008000 (max 255 + min 1 = 256, >>1 = 128).
- Mirror run twice back to back (second start in the first IDLE cycle after done): frame equals the original preload and the second start is accepted.
- start re-pulsed at cycle 100 of a grayscale run, with mode toggled: required response is unchanged total length, no restart, and the grayscale result as in the second scenario.
- rst_n pulsed low at cycle 300 of a mirror run. Required response:
  - we=0, busy=0, row=col=0 immediately, and no done pulse.
  - A subsequent start runs to completion with the correct cycle count.

Source files
------------

// File: rtl/image_proc_ctrl_if.sv
// Bus between the transform sequencer and its surroundings: start/mode
// control from the top level, plus the image memory address/data ports.
`timescale 1ns/1ps
interface image_proc_ctrl_if;
  logic        start;
  logic        mode;
  logic        busy;
  logic        done;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        we;
  logic [23:0] out_pix;
  logic [23:0] in_pix;

  // Sequencer side: owns the memory ports, consumes start/mode and read data.
  modport master (
    input  start, mode, in_pix,
    output busy, done, row, col, we, out_pix
  );

  // Environment side: top-level control plus the image memory.
  modport slave (
    output start, mode, in_pix,
    input  busy, done, row, col, we, out_pix
  );
endinterface

// File: rtl/image_proc_ctrl.sv
// In-place transform sequencer for a 64x64x24-bit image memory.
// Performs a vertical mirror (3 cycles per row pair pixel) or a grayscale
// conversion (1 cycle per pixel), then pulses done for one cycle.
`timescale 1ns/1ps
module image_proc_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  image_proc_ctrl_if.master   bus
);

  typedef enum logic [2:0] {IDLE, MR_TOP, MR_BOT, MR_WB, GRAY, DONE} state_t;

  state_t      state, state_nx;
  logic        mode_q, mode_nx;
  logic [5:0]  r_q, c_q, r_nx, c_nx;
  logic [5:0]  row_q, col_q, row_nx, col_nx;
  logic [23:0] top_buf, bot_buf, top_nx, bot_nx;
  logic        last;
  logic        we, busy, done;
  logic [23:0] out_pix;

  function automatic logic [7:0] max3(input logic [7:0] a, b, c);
    logic [7:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, b, c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Midpoint of the extreme channels; 9-bit sum keeps the carry before the shift.
  function automatic logic [7:0] gray_of(input logic [23:0] p);
    logic [8:0] sum;
    sum = {1'b0, max3(p[23:16], p[15:8], p[7:0])} +
          {1'b0, min3(p[23:16], p[15:8], p[7:0])};
    return sum[8:1];
  endfunction

  // Last pixel of the operation: row 31 for mirror pairs, row 63 for grayscale.
  assign last = (c_q == 6'd63) && (r_q == (mode_q ? 6'd63 : 6'd31));

  // State, counters, address and buffer registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      top_buf <= '0;
      bot_buf <= '0;
    end else begin
      state   <= state_nx;
      mode_q  <= mode_nx;
      r_q     <= r_nx;
      c_q     <= c_nx;
      row_q   <= row_nx;
      col_q   <= col_nx;
      top_buf <= top_nx;
      bot_buf <= bot_nx;
    end
  end

  // Next-state, counter advance and next memory address.
  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    r_nx     = r_q;
    c_nx     = c_q;
    row_nx   = row_q;
    col_nx   = col_q;
    top_nx   = top_buf;
    bot_nx   = bot_buf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_nx  = bus.mode;
          r_nx     = '0;
          c_nx     = '0;
          row_nx   = '0;
          col_nx   = '0;
          state_nx = bus.mode ? GRAY : MR_TOP;
        end
      end
      MR_TOP: begin
        top_nx   = bus.in_pix;
        row_nx   = 6'd63 - r_q;
        state_nx = MR_BOT;
      end
      MR_BOT: begin
        // Old bottom pixel is read while the top pixel lands at the same edge.
        bot_nx   = bus.in_pix;
        row_nx   = r_q;
        state_nx = MR_WB;
      end
      MR_WB, GRAY: begin
        c_nx = c_q + 6'd1;
        if (c_q == 6'd63) r_nx = r_q + 6'd1;
        if (last) begin
          state_nx = DONE;
          row_nx   = '0;
          col_nx   = '0;
        end else begin
          state_nx = (state == GRAY) ? GRAY : MR_TOP;
          row_nx   = r_nx;
          col_nx   = c_nx;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes and status decoded from the current state.
  always_comb begin
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    out_pix = '0;
    case (state)
      MR_TOP: busy = 1'b1;
      MR_BOT: begin
        busy    = 1'b1;
        we      = 1'b1;
        out_pix = top_buf;
      end
      MR_WB: begin
        busy    = 1'b1;
        we      = 1'b1;
        out_pix = bot_buf;
      end
      GRAY: begin
        busy    = 1'b1;
        we      = 1'b1;
        out_pix = {8'h00, gray_of(bus.in_pix), 8'h00};
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.row     = row_q;
  assign bus.col     = col_q;
  assign bus.we      = we;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.out_pix = out_pix;

endmodule

// File: tb/tb_image_proc_ctrl.sv
// Bench for image_proc_ctrl: behavioural image memory, reference frame model
// feeding an expected-write queue, and per-scenario checking tasks.
`timescale 1ns/1ps
module tb_image_proc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  image_proc_ctrl_if bus ();

  image_proc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] mem [64][64];
  logic [23:0] ref_frame [64][64];
  logic [35:0] exp_q [$];
  logic        load_en = 1'b0;
  logic        load_sel = 1'b0;

  assign bus.in_pix = mem[bus.row][bus.col];

  // Memory: preload port and the DUT write port share one process.
  always @(posedge clk) begin
    if (load_en) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++)
          mem[r][c] <= load_sel ? 24'hFF8001 : 24'(r + c);
    end else if (bus.we) begin
      mem[bus.row][bus.col] <= bus.out_pix;
    end
  end

  // Scoreboard: every write must match the next expected (row, col, data).
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_extra_write got row=%0d col=%0d pix=%h expected none",
                   bus.row, bus.col, bus.out_pix);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({bus.row, bus.col, bus.out_pix} !== e) begin
            failures++;
            $display("FAIL scoreboard_write got row=%0d col=%0d pix=%h expected row=%0d col=%0d pix=%h",
                     bus.row, bus.col, bus.out_pix, e[35:30], e[29:24], e[23:0]);
          end
        end
      end else begin
        checks++;
        if (bus.out_pix !== 24'h0) begin
          failures++;
          $display("FAIL out_pix_idle got %h expected 000000", bus.out_pix);
        end
      end
    end
  end

  function automatic logic [23:0] gray_ref(input logic [23:0] p);
    int rr, gg, bb, mx, mn;
    rr = p[23:16]; gg = p[15:8]; bb = p[7:0];
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    return {8'h00, 8'((mx + mn) / 2), 8'h00};
  endfunction

  task automatic preload(input logic sel);
    @(negedge clk);
    load_sel = sel;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        ref_frame[r][c] = sel ? 24'hFF8001 : 24'(r + c);
  endtask

  // Queue the writes one operation should produce and update the reference frame.
  task automatic push_expected(input logic m);
    logic [23:0] t, b;
    if (!m) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 64; c++) begin
          t = ref_frame[r][c];
          b = ref_frame[63-r][c];
          exp_q.push_back({6'(63 - r), 6'(c), t});
          exp_q.push_back({6'(r), 6'(c), b});
          ref_frame[r][c]    = b;
          ref_frame[63-r][c] = t;
        end
    end else begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++) begin
          t = gray_ref(ref_frame[r][c]);
          exp_q.push_back({6'(r), 6'(c), t});
          ref_frame[r][c] = t;
        end
    end
  endtask

  // Pulse start and follow the run; optional start re-pulse or reset at a cycle.
  task automatic run_op(input logic m, input int poke_k, input int rst_k, input int limit,
                        output int busy_n, output int done_k);
    busy_n = 0;
    done_k = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (poke_k != 0 && k == poke_k) begin bus.start = 1'b1; bus.mode = ~m; end
      if (poke_k != 0 && k == poke_k + 1) bus.start = 1'b0;
      if (rst_k != 0 && k == rst_k) begin rst_n = 1'b0; return; end
      if (bus.busy) busy_n++;
      if (bus.done) begin done_k = k; return; end
    end
  endtask

  int frame_bad;

  task automatic test_reset;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.we, bus.busy, bus.done, bus.row, bus.col, bus.out_pix} !== 39'h0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b busy=%b done=%b row=%0d col=%0d pix=%h expected all zero",
               bus.we, bus.busy, bus.done, bus.row, bus.col, bus.out_pix);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mirror;
    int busy_n, done_k;
    preload(1'b0);
    push_expected(1'b0);
    run_op(1'b0, 0, 0, 7000, busy_n, done_k);
    checks++; if (busy_n !== 6144) begin failures++; $display("FAIL mirror_busy got %0d expected 6144", busy_n); end
    checks++; if (done_k !== 6145) begin failures++; $display("FAIL mirror_done_cycle got %0d expected 6145", done_k); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mirror_done_width got %b expected 0", bus.done); end
    checks++; if (mem[0][5] !== 24'd68) begin failures++; $display("FAIL mirror_px_0_5 got %h expected %h", mem[0][5], 24'd68); end
    checks++; if (mem[63][5] !== 24'd5) begin failures++; $display("FAIL mirror_px_63_5 got %h expected %h", mem[63][5], 24'd5); end
    checks++; if (mem[31][0] !== 24'd32) begin failures++; $display("FAIL mirror_px_31_0 got %h expected %h", mem[31][0], 24'd32); end
    checks++; if (mem[32][0] !== 24'd31) begin failures++; $display("FAIL mirror_px_32_0 got %h expected %h", mem[32][0], 24'd31); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL mirror_missing_writes got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_gray;
    int busy_n, done_k;
    preload(1'b0);
    push_expected(1'b1);
    run_op(1'b1, 0, 0, 5000, busy_n, done_k);
    checks++; if (busy_n !== 4096) begin failures++; $display("FAIL gray_busy got %0d expected 4096", busy_n); end
    checks++; if (done_k !== 4097) begin failures++; $display("FAIL gray_done_cycle got %0d expected 4097", done_k); end
    checks++; if (mem[10][20] !== 24'h000F00) begin failures++; $display("FAIL gray_px_10_20 got %h expected 000f00", mem[10][20]); end
    checks++; if (mem[63][63] !== 24'h003F00) begin failures++; $display("FAIL gray_px_63_63 got %h expected 003f00", mem[63][63]); end
    checks++; if (mem[0][0] !== 24'h000000) begin failures++; $display("FAIL gray_px_0_0 got %h expected 000000", mem[0][0]); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL gray_missing_writes got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_gray_carry;
    int busy_n, done_k;
    preload(1'b1);
    push_expected(1'b1);
    run_op(1'b1, 0, 0, 5000, busy_n, done_k);
    frame_bad = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r][c] !== 24'h008000) frame_bad++;
    checks++; if (frame_bad !== 0) begin failures++; $display("FAIL gray_carry_frame got %0d bad pixels expected 0 (mem[0][0]=%h)", frame_bad, mem[0][0]); end
    checks++; if (done_k !== 4097) begin failures++; $display("FAIL gray_carry_done got %0d expected 4097", done_k); end
  endtask

  task automatic test_back_to_back;
    int busy_n, done_k;
    preload(1'b0);
    push_expected(1'b0);
    run_op(1'b0, 0, 0, 7000, busy_n, done_k);
    checks++; if (done_k !== 6145) begin failures++; $display("FAIL b2b_first_done got %0d expected 6145", done_k); end
    // Start raised during DONE must be ignored, then accepted in the IDLE cycle.
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    push_expected(1'b0);
    run_op(1'b0, 0, 0, 7000, busy_n, done_k);
    checks++; if (busy_n !== 6144) begin failures++; $display("FAIL b2b_second_busy got %0d expected 6144", busy_n); end
    checks++; if (done_k !== 6145) begin failures++; $display("FAIL b2b_second_done got %0d expected 6145", done_k); end
    frame_bad = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r][c] !== 24'(r + c)) frame_bad++;
    checks++; if (frame_bad !== 0) begin failures++; $display("FAIL b2b_frame_restored got %0d bad pixels expected 0", frame_bad); end
  endtask

  task automatic test_start_ignored;
    int busy_n, done_k;
    preload(1'b0);
    push_expected(1'b1);
    run_op(1'b1, 100, 0, 5000, busy_n, done_k);
    checks++; if (busy_n !== 4096) begin failures++; $display("FAIL restart_busy got %0d expected 4096", busy_n); end
    checks++; if (done_k !== 4097) begin failures++; $display("FAIL restart_done got %0d expected 4097", done_k); end
    checks++; if (mem[10][20] !== 24'h000F00) begin failures++; $display("FAIL restart_px_10_20 got %h expected 000f00", mem[10][20]); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL restart_missing_writes got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset;
    int busy_n, done_k;
    int saw_done;
    preload(1'b0);
    push_expected(1'b0);
    run_op(1'b0, 0, 300, 7000, busy_n, done_k);
    #1;
    checks++;
    if ({bus.we, bus.busy, bus.row, bus.col} !== 14'h0) begin
      failures++;
      $display("FAIL async_reset_now got we=%b busy=%b row=%0d col=%0d expected 0 0 0 0",
               bus.we, bus.busy, bus.row, bus.col);
    end
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) saw_done++;
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (bus.done) saw_done++;
    end
    checks++; if (saw_done !== 0) begin failures++; $display("FAIL async_reset_no_done got %0d pulses expected 0", saw_done); end
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        ref_frame[r][c] = mem[r][c];
    push_expected(1'b0);
    run_op(1'b0, 0, 0, 7000, busy_n, done_k);
    checks++; if (busy_n !== 6144) begin failures++; $display("FAIL after_reset_busy got %0d expected 6144", busy_n); end
    checks++; if (done_k !== 6145) begin failures++; $display("FAIL after_reset_done got %0d expected 6145", done_k); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL after_reset_missing_writes got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_mirror();
    test_gray();
    test_gray_carry();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
